harm_readout: RTL

- Reader for the harmonic-result output RAM that the accumulator/control block fills: Re, Im and U per bin.
- On a Start pulse it sweeps all bins and packs each RAM word into 16-bit words.
- It emits a framed stream (header, frame number, payload, checksum) to the host link over a valid/ready handshake.
- Sits between the output RAM read port and the transmit interface.

---
 rtl/harm_readout_pkg.sv | 23 ++
 rtl/harm_readout_tx_word_mux.sv | 38 +++
 rtl/harm_readout.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/harm_readout_pkg.sv
// Shared constants and FSM encoding for the harmonic-result RAM readout.
package harm_readout_pkg;

  localparam int unsigned RE_LSB = 0;
  localparam int unsigned IM_LSB = 20;
  localparam int unsigned U_LSB  = 40;
  localparam int unsigned RE_W   = 20;
  localparam int unsigned IM_W   = 20;
  localparam int unsigned U_W    = 19;

  localparam logic [15:0] HEADER_WORD = 16'hA55A;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    FCNT,
    FETCH,
    WAIT,
    SEND,
    CSUM
  } state_e;

endpackage

// File: rtl/harm_readout_tx_word_mux.sv
// Registered stream-word source: loads either a direct word or a 16-bit slice of P,
// and holds it between loads so TxData stays stable under backpressure.
module harm_readout_tx_word_mux (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        load_i,
  input  logic        use_p_i,
  input  logic [15:0] word_i,
  input  logic [63:0] p_i,
  input  logic [1:0]  idx_i,
  output logic [15:0] data_o
);

  logic [15:0] slice;
  logic [15:0] data_q;

  // Word 0 is the most significant slice.
  always_comb begin
    slice = p_i[63:48];
    unique case (idx_i)
      2'd0: slice = p_i[63:48];
      2'd1: slice = p_i[47:32];
      2'd2: slice = p_i[31:16];
      2'd3: slice = p_i[15:0];
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q <= '0;
    end else if (load_i) begin
      data_q <= use_p_i ? slice : word_i;
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/harm_readout.sv
// Sweeps the harmonic output RAM on Start and emits a framed 16-bit stream:
// header, frame number, 4 words per bin, checksum.
module harm_readout
  import harm_readout_pkg::*;
#(
  parameter int unsigned NUM_BINS = 256,
  parameter int unsigned ADDR_W   = 8,
  parameter logic [15:0] HEADER   = HEADER_WORD
) (
  input  logic              ClockFromGen,
  input  logic              Reset,
  input  logic              Start,
  output logic              RdEn,
  output logic [ADDR_W-1:0] RdAddr,
  input  logic [58:0]       RdData,
  output logic [15:0]       TxData,
  output logic              TxValid,
  input  logic              TxReady,
  output logic              Busy,
  output logic              FrameDone,
  output logic              Overrun
);

  localparam logic [ADDR_W-1:0] LastBin = ADDR_W'(NUM_BINS - 1);

  state_e            state_q;
  logic              rd_en_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [ADDR_W-1:0] bin_q;
  logic              tx_valid_q;
  logic              busy_q;
  logic              frame_done_q;
  logic              overrun_q;
  logic [15:0]       fcnt_q;
  logic [15:0]       csum_q;
  logic [1:0]        word_idx_q;
  logic [63:0]       p_q;
  logic [63:0]       p_d;

  logic        xfer;
  logic        last_word;
  logic        last_bin;
  logic        accept;
  logic [15:0] csum_sum;
  logic        mux_load;
  logic        mux_use_p;
  logic [15:0] mux_word;
  logic [1:0]  mux_idx;

  assign xfer      = tx_valid_q & TxReady;
  assign last_word = (word_idx_q == 2'd3);
  assign last_bin  = (bin_q == LastBin);
  // A Start coinciding with FrameDone is treated as arriving while busy.
  assign accept    = Start & ~frame_done_q;
  assign csum_sum  = csum_q + TxData;

  // Mux load is decided alongside the FSM transition so the new word appears with TxValid.
  always_comb begin
    p_d       = p_q;
    mux_load  = 1'b0;
    mux_use_p = 1'b0;
    mux_word  = HEADER;
    mux_idx   = word_idx_q;
    unique case (state_q)
      IDLE: mux_load = accept;
      HDR: begin
        mux_load = xfer;
        mux_word = fcnt_q;
      end
      WAIT: begin
        p_d       = {5'b0, RdData[U_LSB +: U_W], RdData[IM_LSB +: IM_W], RdData[RE_LSB +: RE_W]};
        mux_load  = 1'b1;
        mux_use_p = 1'b1;
        mux_idx   = 2'd0;
      end
      SEND: begin
        if (xfer && !last_word) begin
          mux_load  = 1'b1;
          mux_use_p = 1'b1;
          mux_idx   = word_idx_q + 2'd1;
        end else if (xfer && last_bin) begin
          mux_load = 1'b1;
          mux_word = csum_sum;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge ClockFromGen or negedge Reset) begin
    if (!Reset) begin
      state_q      <= IDLE;
      rd_en_q      <= 1'b0;
      rd_addr_q    <= '0;
      bin_q        <= '0;
      tx_valid_q   <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
      fcnt_q       <= '0;
      csum_q       <= '0;
      word_idx_q   <= '0;
      p_q          <= '0;
    end else begin
      frame_done_q <= 1'b0;
      if (Start && (busy_q || frame_done_q)) overrun_q <= 1'b1;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            state_q    <= HDR;
            tx_valid_q <= 1'b1;
            busy_q     <= 1'b1;
            overrun_q  <= 1'b0;
            csum_q     <= '0;
          end
        end
        HDR: if (xfer) state_q <= FCNT;
        FCNT: begin
          if (xfer) begin
            csum_q     <= csum_sum;
            tx_valid_q <= 1'b0;
            rd_en_q    <= 1'b1;
            rd_addr_q  <= bin_q;
            state_q    <= FETCH;
          end
        end
        FETCH: begin
          rd_en_q <= 1'b0;
          state_q <= WAIT;
        end
        WAIT: begin
          p_q        <= p_d;
          word_idx_q <= 2'd0;
          tx_valid_q <= 1'b1;
          state_q    <= SEND;
        end
        SEND: begin
          if (xfer) begin
            csum_q <= csum_sum;
            if (!last_word) begin
              word_idx_q <= word_idx_q + 2'd1;
            end else if (last_bin) begin
              state_q <= CSUM;
            end else begin
              bin_q      <= bin_q + 1'b1;
              rd_addr_q  <= bin_q + 1'b1;
              rd_en_q    <= 1'b1;
              tx_valid_q <= 1'b0;
              state_q    <= FETCH;
            end
          end
        end
        CSUM: begin
          if (xfer) begin
            tx_valid_q   <= 1'b0;
            frame_done_q <= 1'b1;
            fcnt_q       <= fcnt_q + 16'd1;
            busy_q       <= 1'b0;
            bin_q        <= '0;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  harm_readout_tx_word_mux u_tx_word_mux (
    .clk_i   (ClockFromGen),
    .rst_ni  (Reset),
    .load_i  (mux_load),
    .use_p_i (mux_use_p),
    .word_i  (mux_word),
    .p_i     (p_d),
    .idx_i   (mux_idx),
    .data_o  (TxData)
  );

  assign RdEn      = rd_en_q;
  assign RdAddr    = rd_addr_q;
  assign TxValid   = tx_valid_q;
  assign Busy      = busy_q;
  assign FrameDone = frame_done_q;
  assign Overrun   = overrun_q;

endmodule
